// File: rtl/interp_pkg.sv
// Shared types and default sizes for the segment sequencer.
package interp_pkg;

  localparam int unsigned DEF_W           = 32;
  localparam int unsigned DEF_PW          = 40;
  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 32'd1 << 20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/seg_fifo.sv
// Synchronous FIFO with flush; the head word is always visible on rdata.
module seg_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  // Pointer and occupancy update; flush wins over push/pop, push into a full FIFO only with a pop.
  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/interp_segment_sequencer.sv
// Feeds queued linear-move segments to the CPDDA engine one at a time,
// tracks absolute step position and handles abort and watchdog timeout.
module interp_segment_sequencer
  import interp_pkg::*;
#(
  parameter int unsigned W           = DEF_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned PW          = DEF_PW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        seg_valid,
  output logic                        seg_ready,
  input  logic [W-1:0]                seg_xe,
  input  logic [W-1:0]                seg_ye,
  input  logic                        abort,
  output logic                        eng_purview,
  output logic                        eng_reset,
  output logic [W-1:0]                eng_xe,
  output logic [W-1:0]                eng_ye,
  input  logic                        eng_ax,
  input  logic                        eng_fax,
  input  logic                        eng_ay,
  input  logic                        eng_fay,
  input  logic                        eng_busy,
  output logic                        seg_done,
  output logic                        busy,
  output logic signed [PW-1:0]        pos_x,
  output logic signed [PW-1:0]        pos_y,
  output logic [$clog2(DEPTH):0]      q_level,
  output logic                        err_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
  logic [W-1:0]    xe_q, xe_d, ye_q, ye_d;
  logic            eng_reset_q, eng_reset_d;
  logic            purview_q, purview_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [PW-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;

  logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [2*W-1:0]  fifo_rdata;

  assign seg_ready = !fifo_full && !err_q;
  assign fifo_push = seg_valid && seg_ready && !abort;

  seg_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({seg_xe, seg_ye}),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  // Next-state, watchdog, position and engine-control decode.
  always_comb begin
    state_d     = state_q;
    wd_cnt_d    = wd_cnt_q;
    err_d       = err_q;
    xe_d        = xe_q;
    ye_d        = ye_q;
    eng_reset_d = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    abort_d     = abort;
    pos_x_d     = pos_x_q + PW'(eng_ax) - PW'(eng_fax);
    pos_y_d     = pos_y_q + PW'(eng_ay) - PW'(eng_fay);

    if (abort) begin
      // Level abort holds everything idle; the engine is reset once per abort assertion.
      state_d     = S_IDLE;
      fifo_flush  = 1'b1;
      eng_reset_d = !abort_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            xe_d     = fifo_rdata[2*W-1:W];
            ye_d     = fifo_rdata[W-1:0];
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = ((xe_q == '0) && (ye_q == '0)) ? S_DONE : S_START;
        end
        S_START: begin
          wd_cnt_d = '0;
          state_d  = S_RUN;
        end
        S_RUN: begin
          if (!eng_busy) begin
            state_d = S_DONE;
          end else if (wd_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            err_d       = 1'b1;
            fifo_flush  = 1'b1;
            eng_reset_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (state_d == S_LOAD) eng_reset_d = 1'b1;
    purview_d = (state_d != S_IDLE);
    done_d    = (state_q == S_DONE) && !abort;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
      xe_q        <= '0;
      ye_q        <= '0;
      eng_reset_q <= 1'b0;
      purview_q   <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
      xe_q        <= xe_d;
      ye_q        <= ye_d;
      eng_reset_q <= eng_reset_d;
      purview_q   <= purview_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
    end
  end

  assign eng_purview = purview_q;
  assign eng_reset   = eng_reset_q;
  assign eng_xe      = xe_q;
  assign eng_ye      = ye_q;
  assign seg_done    = done_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_interp_segment_sequencer.sv
// Bench for interp_segment_sequencer: behavioural engine, segment scoreboard, directed and random phases.
module tb_interp_segment_sequencer;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;
  localparam int unsigned PW    = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset, seg_valid, seg_ready, abort;
  logic signed [W-1:0]      seg_xe, seg_ye, eng_xe, eng_ye;
  logic                     eng_purview, eng_reset;
  logic                     eng_ax, eng_fax, eng_ay, eng_fay, eng_busy;
  logic                     seg_done, busy, err_timeout;
  logic signed [PW-1:0]     pos_x, pos_y;
  logic [$clog2(DEPTH):0]   q_level;

  interp_segment_sequencer #(
    .W(W), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .PW(PW)
  ) dut (
    .clk(clk), .reset(reset), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_xe(seg_xe), .seg_ye(seg_ye), .abort(abort),
    .eng_purview(eng_purview), .eng_reset(eng_reset), .eng_xe(eng_xe), .eng_ye(eng_ye),
    .eng_ax(eng_ax), .eng_fax(eng_fax), .eng_ay(eng_ay), .eng_fay(eng_fay), .eng_busy(eng_busy),
    .seg_done(seg_done), .busy(busy), .pos_x(pos_x), .pos_y(pos_y),
    .q_level(q_level), .err_timeout(err_timeout)
  );

  typedef struct { int x; int y; int dt; } ent_t;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     load_cnt = 0;
  int     load_cyc = 0;
  longint exp_x, exp_y;
  int     rem_x, rem_y;
  bit     stall = 1'b0;
  bit     rnd_pulse = 1'b0;
  ent_t   done_q[$];
  ent_t   sb_q[$];
  ent_t   mon_e;

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: takes the endpoint on LOAD, walks it one step per axis per cycle, optional busy hold.
  always @(negedge clk) begin
    eng_ax = 1'b0; eng_fax = 1'b0; eng_ay = 1'b0; eng_fay = 1'b0;
    if (reset) begin
      exp_x = 0; exp_y = 0; rem_x = 0; rem_y = 0; eng_busy = 1'b0;
    end else if (eng_reset) begin
      if (eng_purview) begin
        rem_x = eng_xe; rem_y = eng_ye;
        eng_busy = (rem_x != 0) || (rem_y != 0);
      end else begin
        rem_x = 0; rem_y = 0; eng_busy = 1'b0;
      end
    end else if (eng_busy) begin
      if (rem_x == 0 && rem_y == 0) eng_busy = stall;
      else begin
        if (rem_x > 0) begin eng_ax = 1'b1; rem_x--; end
        else if (rem_x < 0) begin eng_fax = 1'b1; rem_x++; end
        if (rem_y > 0) begin eng_ay = 1'b1; rem_y--; end
        else if (rem_y < 0) begin eng_fay = 1'b1; rem_y++; end
      end
    end else if (rnd_pulse) begin
      eng_ax = 1'($urandom); eng_fax = 1'($urandom);
      eng_ay = 1'($urandom); eng_fay = 1'($urandom);
    end
    exp_x += longint'(eng_ax) - longint'(eng_fax);
    exp_y += longint'(eng_ay) - longint'(eng_fay);
  end

  // Monitor: LOAD times and completed segments with their LOAD-to-done distance.
  always @(negedge clk) begin
    if (!reset) begin
      if (eng_reset && eng_purview) begin
        load_cnt++;
        load_cyc = cyc;
      end
      if (seg_done) begin
        mon_e.x = eng_xe; mon_e.y = eng_ye; mon_e.dt = cyc - load_cyc;
        done_q.push_back(mon_e);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; rnd_pulse = 1'b0; abort = 1'b0; seg_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    done_q.delete(); sb_q.delete();
  endtask

  task automatic push(input int x, input int y);
    ent_t e;
    int n = 0;
    seg_valid = 1'b1; seg_xe = x; seg_ye = y;
    while (!seg_ready && n < 200) begin tick(); n++; end
    if (!seg_ready) check("push_timeout", seg_ready, 1);
    tick();
    seg_valid = 1'b0;
    e.x = x; e.y = y; e.dt = 0;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    if (busy) check({tag, "_idle_timeout"}, busy, 0);
    tick();
  endtask

  task automatic check_sb(input string tag);
    ent_t d, s;
    check({tag, "_done_cnt"}, done_q.size(), sb_q.size());
    while (done_q.size() > 0 && sb_q.size() > 0) begin
      d = done_q.pop_front(); s = sb_q.pop_front();
      check({tag, "_done_x"}, d.x, s.x);
      check({tag, "_done_y"}, d.y, s.y);
    end
    done_q.delete(); sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, n, err_cyc, x, y;
    longint sx, sy;
    reset = 1'b1; seg_valid = 1'b0; seg_xe = 0; seg_ye = 0; abort = 1'b0;
    repeat (3) tick();
    check("rst_ready", seg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", q_level, 0);
    check("rst_pos_x", pos_x, 0);
    check("rst_err", err_timeout, 0);
    check("rst_purview", eng_purview, 0);
    check("rst_eng_reset", eng_reset, 0);
    reset = 1'b0;
    tick();

    // 1: single segment
    push(5, 3);
    wait_idle("t1");
    check("t1_pos_x", pos_x, 5);
    check("t1_pos_y", pos_y, 3);
    check("t1_busy", busy, 0);
    check_sb("t1");

    // 2: back-to-back including a zero-length segment
    do_reset();
    push(-4, 0); push(0, -2); push(0, 0);
    wait_idle("t2");
    check("t2_pos_x", pos_x, -4);
    check("t2_pos_y", pos_y, -2);
    if (done_q.size() == 3) begin
      check("t2_zero_dt", done_q[2].dt, 2);
      check("t2_run_dt", done_q[0].dt > 2, 1);
    end else check("t2_done_n", done_q.size(), 3);
    check_sb("t2");

    // 3: fill the FIFO while the engine is stalled
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 1; i++) push(1, 1);
    check("t3_level_full", q_level, DEPTH);
    check("t3_ready_low", seg_ready, 0);
    seg_valid = 1'b1; seg_xe = 9; seg_ye = 9;
    tick(); tick();
    seg_valid = 1'b0;
    check("t3_level_hold", q_level, DEPTH);
    abort = 1'b1; tick(); abort = 1'b0; tick();
    check("t3_level_flushed", q_level, 0);
    check("t3_no_done", done_q.size(), 0);
    check("t3_pos_x", pos_x, exp_x);

    // 4: abort during RUN of the third of five segments, with a push in the abort cycle
    do_reset();
    base = load_cnt;
    for (int i = 0; i < 5; i++) push(5, 2);
    n = 0;
    while (load_cnt < base + 3 && n < 300) begin tick(); n++; end
    check("t4_third_load", load_cnt, base + 3);
    tick(); tick();
    abort = 1'b1; seg_valid = 1'b1; seg_xe = 1; seg_ye = 1;
    tick();
    abort = 1'b0; seg_valid = 1'b0;
    check("t4_eng_reset", eng_reset, 1);
    check("t4_purview", eng_purview, 0);
    check("t4_level", q_level, 0);
    repeat (30) tick();
    check("t4_busy", busy, 0);
    check("t4_pos_x", pos_x, exp_x);
    check("t4_pos_y", pos_y, exp_y);
    check("t4_partial", (pos_x > 10) && (pos_x < 15), 1);
    while (sb_q.size() > 2) void'(sb_q.pop_back());
    check_sb("t4");

    // 5: watchdog
    do_reset();
    stall = 1'b1;
    push(1, 0);
    n = 0;
    while (!err_timeout && n < 100) begin tick(); n++; end
    check("t5_err", err_timeout, 1);
    err_cyc = cyc;
    check("t5_err_delay", err_cyc - load_cyc, 18);
    check("t5_eng_reset", eng_reset, 1);
    check("t5_purview", eng_purview, 0);
    seg_valid = 1'b1; seg_xe = 2; seg_ye = 2;
    repeat (5) tick();
    seg_valid = 1'b0;
    check("t5_level", q_level, 0);
    check("t5_ready", seg_ready, 0);
    check("t5_err_sticky", err_timeout, 1);
    check("t5_no_done", done_q.size(), 0);

    // 6: reset mid-RUN
    do_reset();
    stall = 1'b1;
    push(7, -1);
    n = 0;
    while (!(pos_x == 7 && pos_y == -1) && n < 50) begin tick(); n++; end
    check("t6_pos_x", pos_x, 7);
    check("t6_pos_y", pos_y, -1);
    check("t6_purview", eng_purview, 1);
    reset = 1'b1; stall = 1'b0;
    tick();
    check("t6_pos_x0", pos_x, 0);
    check("t6_pos_y0", pos_y, 0);
    check("t6_ready", seg_ready, 1);
    check("t6_purview0", eng_purview, 0);
    check("t6_busy", busy, 0);
    check("t6_xe", eng_xe, 0);
    check("t6_done", seg_done, 0);
    reset = 1'b0;
    tick();

    // 7: random step pulses with an idle sequencer, then random segments
    do_reset();
    rnd_pulse = 1'b1;
    repeat (40) tick();
    rnd_pulse = 1'b0;
    tick();
    check("t7_rnd_pos_x", pos_x, exp_x);
    check("t7_rnd_pos_y", pos_y, exp_y);
    sx = pos_x; sy = pos_y;
    for (int i = 0; i < 12; i++) begin
      x = int'($urandom_range(12, 0)) - 6;
      y = int'($urandom_range(12, 0)) - 6;
      sx += x; sy += y;
      push(x, y);
      repeat ($urandom_range(3, 0)) tick();
    end
    wait_idle("t7");
    check("t7_pos_x", pos_x, sx);
    check("t7_pos_y", pos_y, sy);
    check("t7_model_x", pos_x, exp_x);
    check("t7_err", err_timeout, 0);
    check_sb("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
